// File: rtl/mmu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mmu_port_arbiter
// Description : Registered, transaction-locked arbiter that shares the single
//               L1 MMU request port between the I-cache (line reads) and the
//               D-cache (line reads and write-backs). The owner keeps the port
//               from issue until mmu_done, then a one-cycle GAP follows so the
//               finished requester can drop its level request. Round-robin or
//               fixed I-priority selection, plus a sticky hang watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_port_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  // I-cache side
  input  logic         i_req_read,
  input  logic [31:0]  i_req_addr,
  output logic         i_done,
  output logic [255:0] i_read_data,
  // D-cache side
  input  logic         d_req_read,
  input  logic         d_req_write,
  input  logic [31:0]  d_req_addr,
  input  logic [255:0] d_write_data,
  output logic         d_done,
  output logic [255:0] d_read_data,
  // l1mmu side
  output logic         mmu_req_read,
  output logic         mmu_req_write,
  output logic [31:0]  mmu_req_addr,
  output logic [255:0] mmu_write_data,
  input  logic         mmu_done,
  input  logic [255:0] mmu_read_data,
  // status
  output logic         grant_i,
  output logic         grant_d,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam bit               WD_EN     = (TIMEOUT != 0);
  localparam bit               PRIO_I    = (FIXED_PRIO != 0);

  state_t         state_q, state_d;
  logic           last_owner_q, last_owner_d;   // 1 = D-side owned the port last
  logic           req_read_q, req_read_d;
  logic           req_write_q, req_write_d;
  logic [31:0]    req_addr_q, req_addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic           grant_i_q, grant_i_d;
  logic           grant_d_q, grant_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  logic           i_pend;
  logic           d_pend;
  logic           sel_i;
  logic [CNT_W-1:0] cnt_inc;

  assign i_pend  = i_req_read;
  assign d_pend  = d_req_read | d_req_write;
  // I wins when alone, under fixed priority, or when D held the port last.
  assign sel_i   = i_pend & (~d_pend | PRIO_I | last_owner_q);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state, request latching and watchdog computation.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    req_read_d   = req_read_q;
    req_write_d  = req_write_q;
    req_addr_d   = req_addr_q;
    wdata_d      = wdata_q;
    grant_i_d    = grant_i_q;
    grant_d_d    = grant_d_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sel_i) begin
          state_d      = ST_BUSY_I;
          last_owner_d = 1'b0;
          req_read_d   = 1'b1;
          req_write_d  = 1'b0;
          req_addr_d   = i_req_addr;
          grant_i_d    = 1'b1;
        end else if (d_pend) begin
          state_d      = ST_BUSY_D;
          last_owner_d = 1'b1;
          // A simultaneous read+write request is issued as a write.
          req_read_d   = ~d_req_write;
          req_write_d  = d_req_write;
          req_addr_d   = d_req_addr;
          wdata_d      = d_write_data;
          grant_d_d    = 1'b1;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mmu_done) begin
          state_d     = ST_GAP;
          req_read_d  = 1'b0;
          req_write_d = 1'b0;
          grant_i_d   = 1'b0;
          grant_d_d   = 1'b0;
          cnt_d       = '0;
        end else if (WD_EN && (cnt_q != TIMEOUT_C)) begin
          // Saturating count; the transaction keeps waiting after the flag.
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            err_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      req_read_q   <= 1'b0;
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      wdata_q      <= '0;
      grant_i_q    <= 1'b0;
      grant_d_q    <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      req_read_q   <= req_read_d;
      req_write_q  <= req_write_d;
      req_addr_q   <= req_addr_d;
      wdata_q      <= wdata_d;
      grant_i_q    <= grant_i_d;
      grant_d_q    <= grant_d_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Completion is forwarded only to the current owner; data is zero otherwise.
  assign i_done      = (state_q == ST_BUSY_I) & mmu_done;
  assign d_done      = (state_q == ST_BUSY_D) & mmu_done;
  assign i_read_data = i_done ? mmu_read_data : '0;
  assign d_read_data = d_done ? mmu_read_data : '0;

  assign mmu_req_read   = req_read_q;
  assign mmu_req_write  = req_write_q;
  assign mmu_req_addr   = req_addr_q;
  assign mmu_write_data = wdata_q;
  assign grant_i        = grant_i_q;
  assign grant_d        = grant_d_q;
  assign timeout_err    = err_q;

endmodule
`default_nettype wire

// File: doc/mmu_port_arbiter.md
Name: mmu_port_arbiter

Overview:
- Arbitrates the single L1 MMU request port between the L1 I-cache (read-only line fills) and the L1 D-cache (line fills and write-backs).
- Replaces the combinational "I-cache always wins" mux in top with a registered, transaction-locked arbiter. The grant is held from request issue until mmu_done, so ownership can never switch mid-transaction.
- Sits between ifetch/l1dcache and l1mmu. Supports round-robin or fixed-priority arbitration and has a sticky watchdog for hung transactions.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between I and D when both request; 1 = I-side always wins.
- TIMEOUT, 1024, number of busy cycles without mmu_done before timeout_err is set; 0 disables the watchdog.
- CNT_W, 16, width of the watchdog counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req_read  in  1  I-cache line read request, level, held until i_done.
- i_req_addr  in  32  I-cache request address.
- i_done  out  1  one-cycle completion pulse to the I-cache.
- i_read_data  out  256  line data to the I-cache; valid while i_done=1.
- d_req_read  in  1  D-cache line read request, level, held until d_done.
- d_req_write  in  1  D-cache line write request, level, held until d_done.
- d_req_addr  in  32  D-cache request address.
- d_write_data  in  256  D-cache write line.
- d_done  out  1  one-cycle completion pulse to the D-cache.
- d_read_data  out  256  line data to the D-cache; valid while d_done=1.
- mmu_req_read  out  1  registered read request to l1mmu.
- mmu_req_write  out  1  registered write request to l1mmu.
- mmu_req_addr  out  32  registered address to l1mmu.
- mmu_write_data  out  256  registered write line to l1mmu.
- mmu_done  in  1  one-cycle completion pulse from l1mmu.
- mmu_read_data  in  256  line data from l1mmu; valid while mmu_done=1.
- grant_i  out  1  1 while the I-side owns the port.
- grant_d  out  1  1 while the D-side owns the port.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE, last_owner = D, so I wins the first tie.
  - All mmu_req_* = 0; mmu_req_addr and mmu_write_data = 0.
  - grant_i = grant_d = 0, timeout_err = 0, watchdog counter = 0.
  - Reset asserted mid-transaction abandons that transaction with no done pulse. The requester is reset by the same rst_n.
- States: IDLE, BUSY_I, BUSY_D, GAP.
- IDLE:
  - Sample requests; the D-side is pending if d_req_read or d_req_write is 1.
  - If only one side is pending, that side is selected.
  - If both are pending: with FIXED_PRIO=1, I is selected; with FIXED_PRIO=0, the side that is not last_owner is selected.
  - On selection, at the next edge:
    - Latch the owner's address (and D write data) into the mmu_req_* registers.
    - Set the matching request bit and the grant bit, update last_owner, and go to BUSY_x.
  - Latency is one cycle: a request first seen at cycle N gives mmu_req_* asserted at N+1.
  - If d_req_read and d_req_write are both 1, the write wins: mmu_req_write=1 and mmu_req_read=0.
- BUSY_x:
  - mmu_req_* and the grant are held constant; later changes on the requester inputs are ignored.
  - On mmu_done=1, the combinational outputs x_done=1 and x_read_data=mmu_read_data appear in the same cycle; the other side's done stays 0.
  - At the next edge the request bits and grant clear and the state goes to GAP.
- GAP:
  - Lasts exactly one cycle with no grant. This lets the finished requester drop its level request.
  - Then go to IDLE.
  - Net result: the minimum spacing between consecutive MMU requests is 2 idle cycles.
- i_read_data and d_read_data are 0 whenever their own done is 0.
- mmu_done while in IDLE or GAP is ignored, and no done is forwarded.
- Watchdog:
  - Counter = 0 outside BUSY and increments each cycle in BUSY, saturating at TIMEOUT.
  - When it reaches TIMEOUT (TIMEOUT>0), timeout_err is set; only reset clears it.
  - The transaction keeps waiting; it is not aborted.
  - If mmu_done arrives on the same cycle the counter would reach TIMEOUT, done wins and no error is set.

Test Plan:
- Single I read: i_req_read=1, i_req_addr=0x0040_0000 at cycle 0; l1mmu returns done at cycle 5 with data 0xAA..AA. Required: mmu_req_read=1 and addr=0x0040_0000 at cycle 1; i_done=1 with data 0xAA..AA at cycle 5; grant_i drops at cycle 6; d_done=0 throughout.
- Tie, round-robin (FIXED_PRIO=0): I and D (read, 0x1001_0000) both held after reset. Required: I is served first; after done plus GAP, D is granted and mmu_req_addr=0x1001_0000. Re-raising both afterwards grants I again.
- Fixed priority (FIXED_PRIO=1): I and D both continuously requesting. Required: I is granted on every arbitration; D is granted only in an IDLE cycle where i_req_read=0.
- Grant lock: during BUSY_D (write, addr 0x1001_0020), raise i_req_read and change d_req_addr. Required: mmu_req_addr stays 0x1001_0020 and mmu_req_write stays 1 until mmu_done; the I grant comes only after GAP.
- Watchdog (TIMEOUT=8): issue a D read and never return mmu_done. Required: timeout_err=1 after 8 busy cycles and stays high. A later mmu_done still gives d_done=1; timeout_err stays set until rst_n=0.
- Reset mid-transaction: pull rst_n low during BUSY_I. Required: all outputs are 0 immediately (asynchronous); no i_done; the first tie after release goes to I.
